// File: rtl/pio_sram_bridge_if.sv
// +--------------------------------------------------------------------------+
// | pio_sram_bridge_if : PIO command side and async SRAM side of the bridge   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

interface pio_sram_bridge_if #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 16
);
   logic [ADDR_W-1:0] addr_in;
   logic [DATA_W-1:0] wdata_in;
   logic [1:0]        cmd_in;
   logic [DATA_W-1:0] rdata_out;
   logic [2:0]        status_out;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_wdata_oe;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ce_n;
   logic              mem_oe_n;
   logic              mem_we_n;

   // master: software PIOs plus the SRAM device; slave: the bridge itself
   modport master (
      output addr_in, wdata_in, cmd_in, mem_rdata,
      input  rdata_out, status_out, mem_addr, mem_wdata, mem_wdata_oe,
             mem_ce_n, mem_oe_n, mem_we_n
   );

   modport slave (
      input  addr_in, wdata_in, cmd_in, mem_rdata,
      output rdata_out, status_out, mem_addr, mem_wdata, mem_wdata_oe,
             mem_ce_n, mem_oe_n, mem_we_n
   );
endinterface

`default_nettype wire

// File: rtl/pio_sram_bridge.sv
// +--------------------------------------------------------------------------+
// | pio_sram_bridge : one timed async-SRAM read/write per PIO start edge     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module pio_sram_bridge #(
   parameter int ADDR_W      = 11,
   parameter int DATA_W      = 16,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   pio_sram_bridge_if.slave    bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETUP   = 2'd1,
      ACCESS  = 2'd2,
      RECOVER = 2'd3
   } state_t;

   state_t            state;
   logic              start_q;
   logic              is_write;
   logic [3:0]        wait_cnt;
   logic [DATA_W-1:0] rdata;
   logic              overrun;
   logic              done;
   logic              busy;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              wdata_oe;
   logic              ce_n;
   logic              oe_n;
   logic              we_n;
   logic              start_edge;

   assign start_edge = bus.cmd_in[0] & ~start_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         start_q  <= 1'b1;   // a start level held high through reset must not fire
         is_write <= 1'b0;
         wait_cnt <= 4'd0;
         rdata    <= '0;
         overrun  <= 1'b0;
         done     <= 1'b0;
         busy     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wdata_oe <= 1'b0;
         ce_n     <= 1'b1;
         oe_n     <= 1'b1;
         we_n     <= 1'b1;
      end else begin
         start_q <= bus.cmd_in[0];
         if (start_edge && (state != IDLE)) begin
            overrun <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (start_edge) begin
                  addr_q   <= bus.addr_in;
                  wdata_q  <= bus.wdata_in;
                  is_write <= bus.cmd_in[1];
                  wdata_oe <= bus.cmd_in[1];
                  done     <= 1'b0;
                  overrun  <= 1'b0;
                  busy     <= 1'b1;
                  ce_n     <= 1'b0;
                  state    <= SETUP;
               end
            end
            SETUP: begin
               wait_cnt <= 4'(WAIT_CYCLES);
               if (is_write) begin
                  we_n <= 1'b0;
               end else begin
                  oe_n <= 1'b0;
               end
               state <= ACCESS;
            end
            ACCESS: begin
               if (wait_cnt == 4'd0) begin
                  // SRAM data is sampled while oe_n is still low
                  if (!is_write) begin
                     rdata <= bus.mem_rdata;
                  end
                  oe_n  <= 1'b1;
                  we_n  <= 1'b1;
                  state <= RECOVER;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            RECOVER: begin
               ce_n     <= 1'b1;
               wdata_oe <= 1'b0;
               busy     <= 1'b0;
               done     <= 1'b1;
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.rdata_out    = rdata;
   assign bus.status_out   = {overrun, done, busy};
   assign bus.mem_addr     = addr_q;
   assign bus.mem_wdata    = wdata_q;
   assign bus.mem_wdata_oe = wdata_oe;
   assign bus.mem_ce_n     = ce_n;
   assign bus.mem_oe_n     = oe_n;
   assign bus.mem_we_n     = we_n;

endmodule

`default_nettype wire

// File: tb/tb_pio_sram_bridge.sv
// +--------------------------------------------------------------------------+
// | tb_pio_sram_bridge : three bridge builds (WAIT 2/0/15) on shared PIOs    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pio_sram_bridge;

   localparam int NDUT = 3;
   localparam int WAITS [NDUT] = '{2, 0, 15};
   localparam int NSAMP = 21;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [10:0] addr;
   logic [15:0] wdata;
   logic [1:0]  cmd;

   logic [2:0]  st   [NDUT];
   logic [15:0] rd   [NDUT];
   logic        ce_n [NDUT];
   logic        we_n [NDUT];
   logic        oe_n [NDUT];

   int n_chk = 0;
   int n_err = 0;

   logic        exp_wr;
   logic [10:0] exp_addr;
   logic [15:0] exp_wdata;
   logic [15:0] exp_rdata;
   logic [15:0] ref_mem [int];

   always #5 clk = ~clk;

   function automatic logic [15:0] init_pat(input int a);
      return 16'(a * 40503) ^ 16'h5A5A;
   endfunction

   function automatic logic [15:0] ref_read(input int a);
      return ref_mem.exists(a) ? ref_mem[a] : init_pat(a);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      localparam int W = WAITS[g];
      pio_sram_bridge_if #(.ADDR_W(11), .DATA_W(16)) bus ();
      logic [15:0] mem [2048];
      int ce_cnt;
      int stb_cnt;

      pio_sram_bridge #(.ADDR_W(11), .DATA_W(16), .WAIT_CYCLES(W)) u_dut (
         .clk     (clk),
         .reset_n (rst_n),
         .bus     (bus.slave)
      );

      assign bus.addr_in   = addr;
      assign bus.wdata_in  = wdata;
      assign bus.cmd_in    = cmd;
      assign bus.mem_rdata = bus.mem_oe_n ? 16'h0000 : mem[bus.mem_addr];
      assign st[g]   = bus.status_out;
      assign rd[g]   = bus.rdata_out;
      assign ce_n[g] = bus.mem_ce_n;
      assign we_n[g] = bus.mem_we_n;
      assign oe_n[g] = bus.mem_oe_n;

      initial begin
         for (int a = 0; a < 2048; a++) mem[a] = init_pat(a);
      end

      always @(posedge clk) begin
         if (!bus.mem_ce_n && !bus.mem_we_n && bus.mem_wdata_oe) mem[bus.mem_addr] = bus.mem_wdata;
      end

      // SRAM-side protocol monitor: one SETUP, WAIT+1 strobe clocks, one RECOVER
      always @(negedge clk) begin
         if (!rst_n) begin
            ce_cnt  = 0;
            stb_cnt = 0;
         end else if (!bus.mem_ce_n) begin
            ce_cnt++;
            if (!bus.mem_oe_n || !bus.mem_we_n) stb_cnt++;
            chk($sformatf("d%0d_strobe_pos", g), 32'(!bus.mem_oe_n || !bus.mem_we_n),
                32'(ce_cnt >= 2 && ce_cnt <= W + 2));
            chk($sformatf("d%0d_mem_addr", g), 32'(bus.mem_addr), 32'(exp_addr));
            chk($sformatf("d%0d_wdata_oe", g), 32'(bus.mem_wdata_oe), 32'(exp_wr));
            chk($sformatf("d%0d_wrong_strobe", g),
                32'(exp_wr ? bus.mem_oe_n : bus.mem_we_n), 32'd1);
            if (exp_wr) chk($sformatf("d%0d_mem_wdata", g), 32'(bus.mem_wdata), 32'(exp_wdata));
         end else begin
            chk($sformatf("d%0d_strobes_idle", g), 32'({bus.mem_oe_n, bus.mem_we_n}), 32'd3);
            chk($sformatf("d%0d_oe_idle", g), 32'(bus.mem_wdata_oe), 32'd0);
            if (ce_cnt != 0) begin
               chk($sformatf("d%0d_ce_width", g), 32'(ce_cnt), 32'(W + 3));
               chk($sformatf("d%0d_strobe_width", g), 32'(stb_cnt), 32'(W + 1));
               ce_cnt  = 0;
               stb_cnt = 0;
            end
         end
      end
   end

   // Issue one command; r != 0 adds a second start edge r clocks into the cycle
   task automatic run_cmd(input logic wr, input logic [10:0] a, input logic [15:0] d, input int r);
      logic [15:0] new_rd;
      logic        ovr;
      int          w;
      exp_wr    = wr;
      exp_addr  = a;
      exp_wdata = d;
      addr      = a;
      wdata     = d;
      cmd       = {wr, 1'b1};
      if (wr) begin
         ref_mem[int'(a)] = d;
         new_rd = exp_rdata;
      end else begin
         new_rd = ref_read(int'(a));
      end
      for (int k = 1; k <= NSAMP; k++) begin
         @(posedge clk);
         @(negedge clk);
         ovr = (r != 0) && (k >= r + 1);
         for (int i = 0; i < NDUT; i++) begin
            w = WAITS[i];
            chk($sformatf("d%0d_status_k%0d", i, k), 32'(st[i]),
                32'({ovr, (k >= w + 4), (k <= w + 3)}));
            chk($sformatf("d%0d_rdata_k%0d", i, k), 32'(rd[i]),
                32'((k >= w + 3) ? new_rd : exp_rdata));
         end
         if (k == 1) begin
            cmd   = {1'($urandom), 1'b0};
            addr  = 11'($urandom);
            wdata = 16'($urandom);
         end
         if (r != 0 && k == r)     cmd[0] = 1'b1;
         if (r != 0 && k == r + 1) cmd[0] = 1'b0;
      end
      exp_rdata = new_rd;
   endtask

   initial begin
      int unsigned sel;
      int          r;
      logic [10:0] a;
      rst_n     = 1'b0;
      cmd       = 2'b01;
      addr      = '0;
      wdata     = '0;
      exp_wr    = 1'b0;
      exp_addr  = '0;
      exp_wdata = '0;
      exp_rdata = '0;

      repeat (3) @(negedge clk);
      for (int i = 0; i < NDUT; i++) begin
         chk($sformatf("d%0d_rst_status", i), 32'(st[i]), 32'd0);
         chk($sformatf("d%0d_rst_rdata", i), 32'(rd[i]), 32'd0);
         chk($sformatf("d%0d_rst_strobes", i), 32'({ce_n[i], oe_n[i], we_n[i]}), 32'd7);
      end
      #2 rst_n = 1'b1;
      repeat (20) begin
         @(negedge clk);
         for (int i = 0; i < NDUT; i++) begin
            chk($sformatf("d%0d_held_start_status", i), 32'(st[i]), 32'd0);
            chk($sformatf("d%0d_held_start_ce", i), 32'(ce_n[i]), 32'd1);
         end
      end
      cmd = 2'b00;
      @(negedge clk);

      run_cmd(1'b1, 11'h123, 16'hBEEF, 0);
      run_cmd(1'b0, 11'h123, 16'h0000, 0);
      run_cmd(1'b1, 11'h050, 16'h1234, 0);
      run_cmd(1'b1, 11'h055, 16'hAAAA, 2);
      run_cmd(1'b0, 11'h055, 16'h0000, 0);

      // reset dropped while a write strobe is active
      exp_wr    = 1'b1;
      exp_addr  = 11'h7FE;
      exp_wdata = 16'h0F0F;
      addr      = 11'h7FE;
      wdata     = 16'h0F0F;
      cmd       = 2'b11;
      @(posedge clk);
      @(negedge clk);
      cmd[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) chk($sformatf("d%0d_we_before_abort", i), 32'(we_n[i]), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < NDUT; i++) begin
         chk($sformatf("d%0d_abort_strobes", i), 32'({ce_n[i], we_n[i]}), 32'd3);
         chk($sformatf("d%0d_abort_status", i), 32'(st[i]), 32'd0);
         chk($sformatf("d%0d_abort_rdata", i), 32'(rd[i]), 32'd0);
      end
      exp_rdata = '0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);

      run_cmd(1'b0, 11'h123, 16'h0000, 0);
      run_cmd(1'b1, 11'h7FF, 16'h5A5A, 0);
      run_cmd(1'b0, 11'h7FF, 16'h0000, 0);

      for (int n = 0; n < 30; n++) begin
         sel = $urandom_range(0, 9);
         a   = (sel < 8) ? 11'(sel) : ((sel == 8) ? 11'h123 : 11'h7FF);
         case ($urandom_range(0, 3))
            2:       r = 2;
            3:       r = 3;
            default: r = 0;
         endcase
         run_cmd(1'($urandom), a, 16'($urandom), r);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

`default_nettype wire
